nx_msg_mux_decoder: RTL and testbench

//  Multi-channel successor to the single-stream node message decoder. Arbitrates
//  NUM_INPUTS inbound mesh streams (channel index = arrival direction), decodes the

---
 rtl/nx_msg_decoder_pkg.sv | 43 ++++
 rtl/nx_rr_arbiter.sv | 47 ++++
 rtl/nx_msg_mux_decoder.sv | 131 +++++++++++++
 tb/tb_nx_msg_mux_decoder.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nx_msg_decoder_pkg.sv
// Shared types and helpers for the mesh message decoder: direction encoding, header layout, XY routing.
package nx_msg_decoder_pkg;

   typedef enum logic [1:0] {
      DIR_N = 2'd0,
      DIR_E = 2'd1,
      DIR_S = 2'd2,
      DIR_W = 2'd3
   } nx_dir_t;

   localparam int NX_STREAM_WIDTH   = 32;
   localparam int NX_ROW_WIDTH      = 4;
   localparam int NX_COL_WIDTH      = 4;
   localparam int NX_COMMAND_WIDTH  = 2;
   localparam int NX_PAYLOAD_WIDTH  = NX_STREAM_WIDTH - NX_ROW_WIDTH - NX_COL_WIDTH - NX_COMMAND_WIDTH;
   localparam int NX_ADDR_CMP_WIDTH = 16;

   // Header layout of a default-width message, MSB first.
   typedef struct packed {
      logic [NX_ROW_WIDTH-1:0]     row;
      logic [NX_COL_WIDTH-1:0]     col;
      logic [NX_COMMAND_WIDTH-1:0] command;
      logic [NX_PAYLOAD_WIDTH-1:0] payload;
   } nx_hdr_t;

   // XY routing: resolve the row first, then the column; only called for non-local targets.
   function automatic nx_dir_t nx_route(input logic [NX_ADDR_CMP_WIDTH-1:0] row,
                                        input logic [NX_ADDR_CMP_WIDTH-1:0] col,
                                        input logic [NX_ADDR_CMP_WIDTH-1:0] node_row,
                                        input logic [NX_ADDR_CMP_WIDTH-1:0] node_col);
      nx_dir_t dir;
      if (row > node_row)      dir = DIR_S;
      else if (row < node_row) dir = DIR_N;
      else if (col > node_col) dir = DIR_E;
      else                     dir = DIR_W;
      return dir;
   endfunction

   function automatic nx_dir_t nx_reverse(input logic [1:0] arrival);
      return nx_dir_t'(arrival ^ 2'd2);
   endfunction

endpackage

// File: rtl/nx_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at the pointer; pointer moves past the winner on advance.
module nx_rr_arbiter #(
   parameter int N = 4
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [N-1:0] req_i,
   input  logic         advance_i,
   output logic [N-1:0] grant_o,
   output logic [1:0]   grant_idx_o
);

   logic [1:0] ptr_q, ptr_d;
   logic [2:0] cand;
   logic [2:0] next_ptr;
   logic       found;

   // NOTE: every combinational output gets a default before the loop so no latch is inferred.
   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      cand        = '0;
      found       = 1'b0;
      for (int k = 0; k < N; k++) begin
         cand = {1'b0, ptr_q} + 3'(k);
         if (cand >= 3'(N)) cand = cand - 3'(N);
         if (!found && req_i[cand[1:0]]) begin
            found                = 1'b1;
            grant_o[cand[1:0]]   = 1'b1;
            grant_idx_o          = cand[1:0];
         end
      end
   end

   always_comb begin
      next_ptr = {1'b0, grant_idx_o} + 3'd1;
      ptr_d    = ptr_q;
      if (advance_i) ptr_d = (next_ptr >= 3'(N)) ? 2'd0 : next_ptr[1:0];
   end

   // NOTE: state updates use non-blocking assignments; reset is synchronous.
   always_ff @(posedge clk_i) begin
      if (rst_i) ptr_q <= 2'd0;
      else       ptr_q <= ptr_d;
   end

endmodule

// File: rtl/nx_msg_mux_decoder.sv
// Multi-channel mesh message decoder: arbitrates inbound streams, steers to local command or XY bypass.
// Optional broadcast delivery (all-ones address to both ports) enabled by defining NX_MSG_BCAST_EN.
module nx_msg_mux_decoder
   import nx_msg_decoder_pkg::*;
#(
   parameter  int STREAM_WIDTH   = 32,
   parameter  int ADDR_ROW_WIDTH = 4,
   parameter  int ADDR_COL_WIDTH = 4,
   parameter  int COMMAND_WIDTH  = 2,
   parameter  int NUM_INPUTS     = 4,
   localparam int PAYLOAD_WIDTH  = STREAM_WIDTH - ADDR_ROW_WIDTH - ADDR_COL_WIDTH - COMMAND_WIDTH
) (
   input  logic                                     clk_i,
   input  logic                                     rst_i,
   input  logic [ADDR_ROW_WIDTH-1:0]                node_row_i,
   input  logic [ADDR_COL_WIDTH-1:0]                node_col_i,
   input  logic [NUM_INPUTS-1:0][STREAM_WIDTH-1:0]  msg_data_i,
   input  logic [NUM_INPUTS-1:0]                    msg_valid_i,
   output logic [NUM_INPUTS-1:0]                    msg_ready_o,
   output logic [STREAM_WIDTH-1:0]                  bypass_data_o,
   output logic [1:0]                               bypass_dir_o,
   output logic                                     bypass_valid_o,
   input  logic                                     bypass_ready_i,
   output logic [COMMAND_WIDTH-1:0]                 cmd_op_o,
   output logic [PAYLOAD_WIDTH-1:0]                 cmd_payload_o,
   output logic [1:0]                               cmd_src_o,
   output logic                                     cmd_valid_o,
   input  logic                                     cmd_ready_i
);

   localparam int ROW_LSB = STREAM_WIDTH - ADDR_ROW_WIDTH;
   localparam int COL_LSB = ROW_LSB - ADDR_COL_WIDTH;
   localparam int OP_LSB  = COL_LSB - COMMAND_WIDTH;

   logic [NUM_INPUTS-1:0]     grant;
   logic [1:0]                grant_idx;
   logic [STREAM_WIDTH-1:0]   sel_data;
   logic [ADDR_ROW_WIDTH-1:0] sel_row;
   logic [ADDR_COL_WIDTH-1:0] sel_col;
   logic                      reg_free;
   logic                      accept;
   logic                      is_local;
   logic                      is_bcast;
   nx_dir_t                   route_dir;

   logic [STREAM_WIDTH-1:0]   data_q, data_d;
   logic [1:0]                src_q, src_d;
   nx_dir_t                   dir_q, dir_d;
   logic                      pend_cmd_q, pend_cmd_d;
   logic                      pend_byp_q, pend_byp_d;

   // Free for a new message once every pending side completes its handshake this cycle.
   assign reg_free = (!pend_cmd_q || cmd_ready_i) && (!pend_byp_q || bypass_ready_i);
   assign accept   = reg_free && (|msg_valid_i) && !rst_i;

   nx_rr_arbiter #(
      .N (NUM_INPUTS)
   ) u_arb (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .req_i       (msg_valid_i),
      .advance_i   (accept),
      .grant_o     (grant),
      .grant_idx_o (grant_idx)
   );

   assign msg_ready_o = accept ? grant : '0;
   assign sel_data    = msg_data_i[grant_idx];
   assign sel_row     = sel_data[ROW_LSB +: ADDR_ROW_WIDTH];
   assign sel_col     = sel_data[COL_LSB +: ADDR_COL_WIDTH];
   assign is_local    = (sel_row == node_row_i) && (sel_col == node_col_i);
   assign route_dir   = nx_route(NX_ADDR_CMP_WIDTH'(sel_row), NX_ADDR_CMP_WIDTH'(sel_col),
                                 NX_ADDR_CMP_WIDTH'(node_row_i), NX_ADDR_CMP_WIDTH'(node_col_i));

`ifdef NX_MSG_BCAST_EN
   assign is_bcast = (&sel_row) && (&sel_col);
`else
   assign is_bcast = 1'b0;
`endif

   always_comb begin
      data_d     = data_q;
      src_d      = src_q;
      dir_d      = dir_q;
      pend_cmd_d = pend_cmd_q && !cmd_ready_i;
      pend_byp_d = pend_byp_q && !bypass_ready_i;
      if (accept) begin
         data_d = sel_data;
         src_d  = grant_idx;
         if (is_bcast) begin
            pend_cmd_d = 1'b1;
            pend_byp_d = 1'b1;
            dir_d      = nx_reverse(grant_idx);
         end else if (is_local) begin
            pend_cmd_d = 1'b1;
            pend_byp_d = 1'b0;
            dir_d      = DIR_N;
         end else begin
            pend_cmd_d = 1'b0;
            pend_byp_d = 1'b1;
            dir_d      = route_dir;
         end
      end
   end

   // Data fields are cleared too so every output reads zero straight out of reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data_q     <= '0;
         src_q      <= 2'd0;
         dir_q      <= DIR_N;
         pend_cmd_q <= 1'b0;
         pend_byp_q <= 1'b0;
      end else begin
         data_q     <= data_d;
         src_q      <= src_d;
         dir_q      <= dir_d;
         pend_cmd_q <= pend_cmd_d;
         pend_byp_q <= pend_byp_d;
      end
   end

   assign bypass_data_o  = data_q;
   assign bypass_dir_o   = dir_q;
   assign bypass_valid_o = pend_byp_q;
   assign cmd_op_o       = data_q[OP_LSB +: COMMAND_WIDTH];
   assign cmd_payload_o  = data_q[PAYLOAD_WIDTH-1:0];
   assign cmd_src_o      = src_q;
   assign cmd_valid_o    = pend_cmd_q;

endmodule

// File: tb/tb_nx_msg_mux_decoder.sv
// Self-checking bench for nx_msg_mux_decoder: queue-based scoreboard model plus directed literal checks.
// Broadcast scenario is exercised when NX_MSG_BCAST_EN is defined.
module tb_nx_msg_mux_decoder;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic [3:0]       node_row_i, node_col_i;
   logic [3:0][31:0] msg_data_i;
   logic [3:0]       msg_valid_i, msg_ready_o;
   logic [31:0]      bypass_data_o;
   logic [1:0]       bypass_dir_o;
   logic             bypass_valid_o, bypass_ready_i;
   logic [1:0]       cmd_op_o;
   logic [21:0]      cmd_payload_o;
   logic [1:0]       cmd_src_o;
   logic             cmd_valid_o, cmd_ready_i;

   always #5 clk_i = ~clk_i;

   nx_msg_mux_decoder dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .node_row_i     (node_row_i),
      .node_col_i     (node_col_i),
      .msg_data_i     (msg_data_i),
      .msg_valid_i    (msg_valid_i),
      .msg_ready_o    (msg_ready_o),
      .bypass_data_o  (bypass_data_o),
      .bypass_dir_o   (bypass_dir_o),
      .bypass_valid_o (bypass_valid_o),
      .bypass_ready_i (bypass_ready_i),
      .cmd_op_o       (cmd_op_o),
      .cmd_payload_o  (cmd_payload_o),
      .cmd_src_o      (cmd_src_o),
      .cmd_valid_o    (cmd_valid_o),
      .cmd_ready_i    (cmd_ready_i)
   );

   int checks = 0;
   int errors = 0;

   typedef struct { int op; int payload; int src; } cmd_t;
   typedef struct { logic [31:0] data; int dir; } byp_t;

   cmd_t cq[$];
   byp_t bq[$];
   int   mptr;
   int   glog[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected exit direction from plain address comparisons.
   function automatic int xy_dir(input int row, input int col, input int nrow, input int ncol);
      if (row > nrow) return 2;
      if (row < nrow) return 0;
      if (col > ncol) return 1;
      return 3;
   endfunction

   // Scoreboard: at most one outstanding item per port; ordering and grants predicted from the rules.
   always @(negedge clk_i) begin : model
      int          g;
      logic [1:0]  gi;
      bit          free;
      logic [31:0] d;
      int          row, col;
      cmd_t        ce;
      byp_t        be;
      if (rst_i) begin
         cq.delete();
         bq.delete();
         mptr = 0;
         check("ready_in_reset", 32'(msg_ready_o), 32'h0);
      end else begin
         check("cmd_valid", 32'(cmd_valid_o), (cq.size() != 0) ? 32'h1 : 32'h0);
         if (cq.size() != 0) begin
            check("cmd_op", 32'(cmd_op_o), 32'(cq[0].op));
            check("cmd_payload", 32'(cmd_payload_o), 32'(cq[0].payload));
            check("cmd_src", 32'(cmd_src_o), 32'(cq[0].src));
         end
         check("byp_valid", 32'(bypass_valid_o), (bq.size() != 0) ? 32'h1 : 32'h0);
         if (bq.size() != 0) begin
            check("byp_data", bypass_data_o, bq[0].data);
            check("byp_dir", 32'(bypass_dir_o), 32'(bq[0].dir));
         end
         free = (cq.size() == 0 || cmd_ready_i) && (bq.size() == 0 || bypass_ready_i);
         g = -1;
         if (free) begin
            for (int k = 0; k < 4; k++) begin
               if (g < 0 && msg_valid_i[(mptr + k) % 4]) g = (mptr + k) % 4;
            end
         end
         check("msg_ready", 32'(msg_ready_o), (g >= 0) ? (32'h1 << g) : 32'h0);
         for (int k = 0; k < 4; k++) if (msg_ready_o[k]) glog.push_back(k);
         if (cq.size() != 0 && cmd_ready_i)    void'(cq.pop_front());
         if (bq.size() != 0 && bypass_ready_i) void'(bq.pop_front());
         if (g >= 0) begin
            gi  = 2'(g);
            d   = msg_data_i[gi];
            row = int'(d >> 28);
            col = int'((d >> 24) & 32'hF);
            ce.op      = int'((d >> 22) & 32'h3);
            ce.payload = int'(d % 32'h40_0000);
            ce.src     = g;
            be.data    = d;
`ifdef NX_MSG_BCAST_EN
            if (row == 15 && col == 15) begin
               be.dir = (g + 2) % 4;
               cq.push_back(ce);
               bq.push_back(be);
            end else
`endif
            if (row == int'(node_row_i) && col == int'(node_col_i)) begin
               cq.push_back(ce);
            end else begin
               be.dir = xy_dir(row, col, int'(node_row_i), int'(node_col_i));
               bq.push_back(be);
            end
            mptr = (g + 1) % 4;
         end
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic send1(input logic [1:0] ch, input logic [31:0] d);
      bit got;
      int n;
      got = 1'b0;
      n   = 0;
      msg_data_i[ch]  = d;
      msg_valid_i[ch] = 1'b1;
      while (!got && n < 50) begin
         @(negedge clk_i);
         got = msg_ready_o[ch];
         tick();
         n++;
      end
      msg_valid_i[ch] = 1'b0;
      check("send_accept", 32'(got), 32'h1);
   endtask

   logic [31:0] rt_data [4];
   int          rt_dir  [4];
   int          gexp    [5];
   logic [3:0]  cap;

   initial begin
      rt_data = '{32'h0700_0055, 32'h2900_0077, 32'h2100_0088, 32'h5380_0ABC};
      rt_dir  = '{0, 1, 3, 2};
      gexp    = '{0, 1, 2, 3, 0};

      rst_i          = 1'b1;
      node_row_i     = 4'd2;
      node_col_i     = 4'd3;
      msg_data_i     = '0;
      msg_data_i[0]  = 32'h2340_0001;
      msg_valid_i    = 4'b0001;
      cmd_ready_i    = 1'b1;
      bypass_ready_i = 1'b1;
      tick();
      tick();
      @(negedge clk_i);
      check("rst_cmd_valid", 32'(cmd_valid_o), 32'h0);
      check("rst_byp_valid", 32'(bypass_valid_o), 32'h0);
      check("rst_byp_data", bypass_data_o, 32'h0);
      check("rst_byp_dir", 32'(bypass_dir_o), 32'h0);
      check("rst_cmd_op", 32'(cmd_op_o), 32'h0);
      check("rst_cmd_payload", 32'(cmd_payload_o), 32'h0);
      check("rst_cmd_src", 32'(cmd_src_o), 32'h0);
      tick();
      rst_i       = 1'b0;
      msg_valid_i = 4'b0000;

      // Local command from the east channel.
      send1(2'd1, 32'h2340_1234);
      @(negedge clk_i);
      check("local_valid", 32'(cmd_valid_o), 32'h1);
      check("local_op", 32'(cmd_op_o), 32'h1);
      check("local_payload", 32'(cmd_payload_o), 32'h1234);
      check("local_src", 32'(cmd_src_o), 32'h1);
      check("local_no_byp", 32'(bypass_valid_o), 32'h0);
      tick();

      // XY routing table: N, E, W, S.
      for (int i = 0; i < 4; i++) begin
         send1(2'd0, rt_data[i]);
         @(negedge clk_i);
         check("route_valid", 32'(bypass_valid_o), 32'h1);
         check("route_dir", 32'(bypass_dir_o), 32'(rt_dir[i]));
         check("route_data", bypass_data_o, rt_data[i]);
         check("route_no_cmd", 32'(cmd_valid_o), 32'h0);
         tick();
      end

      // Round-robin order from a freshly reset pointer with all channels requesting.
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      for (int k = 0; k < 4; k++) msg_data_i[k] = 32'h2340_0000 + 32'(k);
      msg_valid_i = 4'hF;
      glog.delete();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk_i);
         cap = msg_ready_o;
         tick();
         for (int k = 0; k < 4; k++) if (cap[k]) msg_data_i[k] = msg_data_i[k] + 32'h10;
      end
      msg_valid_i = 4'h0;
      check("grant_count", 32'(glog.size()), 32'd5);
      for (int i = 0; i < 5; i++) begin
         if (glog.size() > i) check("grant_seq", 32'(glog[i]), 32'(gexp[i]));
      end
      tick();

      // Bypass back-pressure: output held, nothing accepted, then drain.
      bypass_ready_i = 1'b0;
      send1(2'd0, 32'h5380_0ABC);
      msg_data_i[2]  = 32'h2340_0002;
      msg_valid_i[2] = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk_i);
         check("stall_valid", 32'(bypass_valid_o), 32'h1);
         check("stall_data", bypass_data_o, 32'h5380_0ABC);
         check("stall_dir", 32'(bypass_dir_o), 32'h2);
         check("stall_ready", 32'(msg_ready_o), 32'h0);
         tick();
      end
      bypass_ready_i = 1'b1;
      @(negedge clk_i);
      check("drain_ready", 32'(msg_ready_o), 32'h4);
      tick();
      msg_valid_i[2] = 1'b0;
      @(negedge clk_i);
      check("drain_cmd_src", 32'(cmd_src_o), 32'h2);
      check("drain_byp_idle", 32'(bypass_valid_o), 32'h0);
      tick();

      // Back-to-back local commands: accepted every cycle.
      msg_data_i[3]  = 32'h2340_0100;
      msg_valid_i[3] = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk_i);
         check("b2b_ready", 32'(msg_ready_o), 32'h8);
         tick();
         msg_data_i[3] = msg_data_i[3] + 32'h1;
      end
      msg_valid_i[3] = 1'b0;
      tick();

      // Reset while a bypass message is stalled drops it.
      bypass_ready_i = 1'b0;
      send1(2'd0, 32'h0700_0055);
      @(negedge clk_i);
      check("pre_rst_valid", 32'(bypass_valid_o), 32'h1);
      tick();
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      @(negedge clk_i);
      check("post_rst_valid", 32'(bypass_valid_o), 32'h0);
      check("post_rst_data", bypass_data_o, 32'h0);
      tick();
      bypass_ready_i = 1'b1;

`ifdef NX_MSG_BCAST_EN
      // Broadcast from west channel with a late local consumer.
      cmd_ready_i = 1'b0;
      send1(2'd3, 32'hFF40_0033);
      @(negedge clk_i);
      check("bcast_cmd_valid", 32'(cmd_valid_o), 32'h1);
      check("bcast_byp_valid", 32'(bypass_valid_o), 32'h1);
      check("bcast_dir", 32'(bypass_dir_o), 32'h1);
      check("bcast_src", 32'(cmd_src_o), 32'h3);
      tick();
      msg_data_i[0]  = 32'h2340_0044;
      msg_valid_i[0] = 1'b1;
      @(negedge clk_i);
      check("bcast_byp_done", 32'(bypass_valid_o), 32'h0);
      check("bcast_cmd_hold", 32'(cmd_valid_o), 32'h1);
      check("bcast_not_free", 32'(msg_ready_o), 32'h0);
      tick();
      cmd_ready_i = 1'b1;
      @(negedge clk_i);
      check("bcast_free", 32'(msg_ready_o), 32'h1);
      tick();
      msg_valid_i[0] = 1'b0;
`else
      // All-ones address is ordinary unicast: routes south from row 2.
      send1(2'd3, 32'hFF40_0033);
      @(negedge clk_i);
      check("ucast_ff_byp", 32'(bypass_valid_o), 32'h1);
      check("ucast_ff_dir", 32'(bypass_dir_o), 32'h2);
      check("ucast_ff_no_cmd", 32'(cmd_valid_o), 32'h0);
      tick();
`endif

      // Local command held under cmd back-pressure.
      cmd_ready_i = 1'b0;
      send1(2'd1, 32'h23C0_0ABC);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk_i);
         check("cmd_hold_op", 32'(cmd_op_o), 32'h3);
         check("cmd_hold_payload", 32'(cmd_payload_o), 32'hABC);
         tick();
      end
      cmd_ready_i = 1'b1;
      repeat (3) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "timeout");
   end

endmodule
